// File: rtl/oled_datapath.sv
// -----------------------------------------------------------------------------
// oled_datapath
//
// Datapath for the soda-machine OLED display. It turns 8-bit cent values into
// fixed 12-character ASCII lines and holds each line in its own register until
// that register's load strobe is pulsed. Sequencing belongs to the OLED
// controller FSM, so this block holds no state beyond the four line registers.
//
// Line layout: char 0 (leftmost) is in bits [95:88], and char 11 is in bits [7:0].
// Money text is "$D.CC", built from a binary-to-BCD conversion of 0..255.
//
// Ports
//   clk        in   1      system clock, rising edge
//   clr_reg    in   1      asynchronous, active-high clear; all lines become spaces
//   ld_price   in   1      load soda_price with "Price: " + fmt(soda)
//   ld_cents   in   1      load coin_val   with "Coin:  " + fmt(cents_in)
//   ld_coins   in   1      load coins_tot  with "Total: " + fmt(coins)
//   ld_disp    in   1      load disp with "Insert "/"Change " + fmt(|soda-coins|)
//   soda       in   8      selected soda price, cents
//   cents_in   in   8      value of the last inserted coin, cents
//   coins      in   8      running total inserted, cents
//   soda_price out  WIDTH  price text line
//   coin_val   out  WIDTH  last-coin text line
//   coins_tot  out  WIDTH  total-inserted text line
//   disp       out  WIDTH  status text line
// -----------------------------------------------------------------------------
module oled_datapath #(
  parameter int WIDTH = 96  // 12 chars x 8 bits; only 96 is supported
) (
  input  logic             clk,
  input  logic             clr_reg,
  input  logic             ld_price,
  input  logic             ld_cents,
  input  logic             ld_coins,
  input  logic             ld_disp,
  input  logic [7:0]       soda,
  input  logic [7:0]       cents_in,
  input  logic [7:0]       coins,
  output logic [WIDTH-1:0] soda_price,
  output logic [WIDTH-1:0] coin_val,
  output logic [WIDTH-1:0] coins_tot,
  output logic [WIDTH-1:0] disp
);

  localparam logic [WIDTH-1:0] BLANK      = {12{8'h20}};
  localparam logic [55:0]      PFX_PRICE  = "Price: ";
  localparam logic [55:0]      PFX_COIN   = "Coin:  ";
  localparam logic [55:0]      PFX_TOTAL  = "Total: ";
  localparam logic [55:0]      PFX_INSERT = "Insert ";
  localparam logic [55:0]      PFX_CHANGE = "Change ";

  // Five-character money field "$D.CC". The conversion uses double dabble:
  // before each shift, any BCD column holding 5 or more gets 3 added, so the
  // column carries correctly into the next decimal digit.
  function automatic logic [39:0] fmt_money(input logic [7:0] v);
    logic [19:0] sh;  // [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary
    sh = {12'd0, v};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = {sh[18:0], 1'b0};
    end
    return {8'h24, {4'h3, sh[19:16]}, 8'h2E, {4'h3, sh[15:12]}, {4'h3, sh[11:8]}};
  endfunction

  logic [WIDTH-1:0] soda_price_d, soda_price_q;
  logic [WIDTH-1:0] coin_val_d,   coin_val_q;
  logic [WIDTH-1:0] coins_tot_d,  coins_tot_q;
  logic [WIDTH-1:0] disp_d,       disp_q;

  // The compare picks the subtraction order, so the difference never wraps.
  logic       coins_short;
  logic [7:0] diff;

  always_comb begin
    coins_short = (coins < soda);
    diff        = coins_short ? (soda - coins) : (coins - soda);
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first (hold the current
    // value), so no path leaves a signal unassigned and no latch is inferred.
    soda_price_d = soda_price_q;
    coin_val_d   = coin_val_q;
    coins_tot_d  = coins_tot_q;
    disp_d       = disp_q;

    if (ld_price) soda_price_d = {PFX_PRICE, fmt_money(soda)};
    if (ld_cents) coin_val_d   = {PFX_COIN,  fmt_money(cents_in)};
    if (ld_coins) coins_tot_d  = {PFX_TOTAL, fmt_money(coins)};
    if (ld_disp)  disp_d       = {(coins_short ? PFX_INSERT : PFX_CHANGE), fmt_money(diff)};
  end

  // Clear is asynchronous and takes priority over any load.
  always_ff @(posedge clk or posedge clr_reg) begin
    if (clr_reg) begin
      // NOTE: non-blocking assignments let every register sample
      // pre-edge values, regardless of statement order.
      soda_price_q <= BLANK;
      coin_val_q   <= BLANK;
      coins_tot_q  <= BLANK;
      disp_q       <= BLANK;
    end else begin
      soda_price_q <= soda_price_d;
      coin_val_q   <= coin_val_d;
      coins_tot_q  <= coins_tot_d;
      disp_q       <= disp_d;
    end
  end

  assign soda_price = soda_price_q;
  assign coin_val   = coin_val_q;
  assign coins_tot  = coins_tot_q;
  assign disp       = disp_q;

endmodule

// File: tb/tb_oled_datapath.sv
// -----------------------------------------------------------------------------
// tb_oled_datapath
//
// Directed, self-checking bench for oled_datapath. Each scenario task drives
// its stimulus and compares outputs against hand-written ASCII lines. Inputs
// change 1 ns after a rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_oled_datapath;

  logic        clk = 1'b0;
  logic        clr_reg;
  logic        ld_price, ld_cents, ld_coins, ld_disp;
  logic [7:0]  soda, cents_in, coins;
  logic [95:0] soda_price, coin_val, coins_tot, disp;

  int tests  = 0;
  int errors = 0;

  localparam logic [95:0] SPACES = {12{8'h20}};

  oled_datapath #(.WIDTH(96)) dut (
    .clk        (clk),
    .clr_reg    (clr_reg),
    .ld_price   (ld_price),
    .ld_cents   (ld_cents),
    .ld_coins   (ld_coins),
    .ld_disp    (ld_disp),
    .soda       (soda),
    .cents_in   (cents_in),
    .coins      (coins),
    .soda_price (soda_price),
    .coin_val   (coin_val),
    .coins_tot  (coins_tot),
    .disp       (disp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input logic p, input logic c, input logic t, input logic d);
    ld_price = p; ld_cents = c; ld_coins = t; ld_disp = d;
  endtask

  task automatic test_reset();
    logic [95:0] exp;
    clr_reg = 1'b1;
    soda = 8'd123; cents_in = 8'd45; coins = 8'd67;
    strobes(1, 1, 1, 1);
    repeat (5) tick();
    exp = SPACES;
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL reset_price got '%s' exp '%s'", soda_price, exp); end
    tests++; if (coin_val   !== exp) begin errors++; $display("FAIL reset_coin got '%s' exp '%s'", coin_val, exp); end
    tests++; if (coins_tot  !== exp) begin errors++; $display("FAIL reset_total got '%s' exp '%s'", coins_tot, exp); end
    tests++; if (disp       !== exp) begin errors++; $display("FAIL reset_disp got '%s' exp '%s'", disp, exp); end
    strobes(0, 0, 0, 0);
    clr_reg = 1'b0;
    tick();
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL post_reset_idle got '%s' exp '%s'", soda_price, exp); end
  endtask

  task automatic test_price();
    logic [95:0] exp;
    soda = 8'd250;
    strobes(1, 0, 0, 0);
    tick();
    strobes(0, 0, 0, 0);
    exp = "Price: $2.50";
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL price_250 got '%s' exp '%s'", soda_price, exp); end
    tests++; if (coin_val  !== SPACES) begin errors++; $display("FAIL price_coin_blank got '%s'", coin_val); end
    tests++; if (coins_tot !== SPACES) begin errors++; $display("FAIL price_total_blank got '%s'", coins_tot); end
    tests++; if (disp      !== SPACES) begin errors++; $display("FAIL price_disp_blank got '%s'", disp); end
  endtask

  task automatic test_cents_coins();
    logic [95:0] exp;
    cents_in = 8'd25;
    strobes(0, 1, 0, 0);
    tick();
    strobes(0, 0, 0, 0);
    exp = "Coin:  $0.25";
    tests++; if (coin_val !== exp) begin errors++; $display("FAIL coin_25 got '%s' exp '%s'", coin_val, exp); end
    coins = 8'd50;
    soda  = 8'd7;  // price must hold even though soda changes
    strobes(0, 0, 1, 0);
    tick();
    strobes(0, 0, 0, 0);
    exp = "Total: $0.50";
    tests++; if (coins_tot !== exp) begin errors++; $display("FAIL total_50 got '%s' exp '%s'", coins_tot, exp); end
    exp = "Coin:  $0.25";
    tests++; if (coin_val !== exp) begin errors++; $display("FAIL coin_held got '%s' exp '%s'", coin_val, exp); end
    exp = "Price: $2.50";
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL price_held got '%s' exp '%s'", soda_price, exp); end
    tests++; if (disp !== SPACES) begin errors++; $display("FAIL disp_still_blank got '%s'", disp); end
  endtask

  task automatic test_disp();
    logic [95:0] exp;
    soda = 8'd250; coins = 8'd50;
    strobes(0, 0, 0, 1);
    tick();
    exp = "Insert $2.00";
    tests++; if (disp !== exp) begin errors++; $display("FAIL disp_insert got '%s' exp '%s'", disp, exp); end
    soda = 8'd150; coins = 8'd255;
    tick();
    exp = "Change $1.05";
    tests++; if (disp !== exp) begin errors++; $display("FAIL disp_change got '%s' exp '%s'", disp, exp); end
    soda = 8'd100; coins = 8'd100;
    tick();
    strobes(0, 0, 0, 0);
    exp = "Change $0.00";
    tests++; if (disp !== exp) begin errors++; $display("FAIL disp_equal got '%s' exp '%s'", disp, exp); end
    soda = 8'd10; coins = 8'd3;  // no strobe: disp and total hold
    tick();
    tests++; if (disp !== exp) begin errors++; $display("FAIL disp_held got '%s' exp '%s'", disp, exp); end
    exp = "Total: $0.50";
    tests++; if (coins_tot !== exp) begin errors++; $display("FAIL total_held got '%s' exp '%s'", coins_tot, exp); end
  endtask

  task automatic test_async_clear();
    logic [95:0] exp;
    clr_reg = 1'b1;
    #2;  // still well before the next rising edge
    tests++; if (soda_price !== SPACES) begin errors++; $display("FAIL async_price got '%s'", soda_price); end
    tests++; if (coin_val   !== SPACES) begin errors++; $display("FAIL async_coin got '%s'", coin_val); end
    tests++; if (coins_tot  !== SPACES) begin errors++; $display("FAIL async_total got '%s'", coins_tot); end
    tests++; if (disp       !== SPACES) begin errors++; $display("FAIL async_disp got '%s'", disp); end
    clr_reg = 1'b0;
    tick();
    soda = 8'd150; cents_in = 8'd10; coins = 8'd100;
    strobes(1, 0, 0, 0);
    tick();
    strobes(0, 0, 0, 0);
    exp = "Price: $1.50";
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL reload_price got '%s' exp '%s'", soda_price, exp); end
    tests++; if (coin_val  !== SPACES) begin errors++; $display("FAIL reload_coin_blank got '%s'", coin_val); end
    tests++; if (coins_tot !== SPACES) begin errors++; $display("FAIL reload_total_blank got '%s'", coins_tot); end
    tests++; if (disp      !== SPACES) begin errors++; $display("FAIL reload_disp_blank got '%s'", disp); end
  endtask

  task automatic test_boundaries();
    logic [95:0] exp;
    soda = 8'd0;
    strobes(1, 0, 0, 0);
    tick();
    exp = "Price: $0.00";
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL price_0 got '%s' exp '%s'", soda_price, exp); end
    soda = 8'd255;
    tick();
    exp = "Price: $2.55";
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL price_255 got '%s' exp '%s'", soda_price, exp); end
    soda = 8'd99;  // held strobe tracks inputs, including a decimal carry
    tick();
    exp = "Price: $0.99";
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL price_99 got '%s' exp '%s'", soda_price, exp); end
    soda = 8'd100;
    tick();
    strobes(0, 0, 0, 0);
    exp = "Price: $1.00";
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL price_100 got '%s' exp '%s'", soda_price, exp); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] exp;
    soda = 8'd200; cents_in = 8'd5; coins = 8'd199;
    strobes(1, 1, 1, 1);
    tick();
    strobes(0, 0, 0, 0);
    exp = "Price: $2.00";
    tests++; if (soda_price !== exp) begin errors++; $display("FAIL all_price got '%s' exp '%s'", soda_price, exp); end
    exp = "Coin:  $0.05";
    tests++; if (coin_val !== exp) begin errors++; $display("FAIL all_coin got '%s' exp '%s'", coin_val, exp); end
    exp = "Total: $1.99";
    tests++; if (coins_tot !== exp) begin errors++; $display("FAIL all_total got '%s' exp '%s'", coins_tot, exp); end
    exp = "Insert $0.01";
    tests++; if (disp !== exp) begin errors++; $display("FAIL all_disp got '%s' exp '%s'", disp, exp); end
  endtask

  initial begin
    clr_reg = 1'b1;
    strobes(0, 0, 0, 0);
    soda = '0; cents_in = '0; coins = '0;
    test_reset();
    test_price();
    test_cents_coins();
    test_disp();
    test_async_clear();
    test_boundaries();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
